// File: rtl/hc_sr04_pkg.sv
// Shared constants, state encoding and elaboration-time helpers for the
// HC-SR04 measurement and filtering blocks.
package hc_sr04_pkg;

    localparam int SOUND_SPEED_M_S = 340;
    localparam int CM_SCALE_LOG2   = 24;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        TRACKING = 2'd1,
        FAULT    = 2'd2
    } dist_filt_state_t;

    // Echo ticks for a round trip to max_m metres (truncated).
    function automatic longint calc_max_ticks(input longint clk_freq, input longint max_m);
        return (clk_freq * 2 * max_m) / SOUND_SPEED_M_S;
    endfunction

    // Ticks-to-cm factor in Q24: cm = ticks * (v*100/2) / f, rounded to nearest.
    function automatic longint calc_k(input longint clk_freq);
        longint num;
        num = (longint'(SOUND_SPEED_M_S) * 50) <<< CM_SCALE_LOG2;
        return (num + clk_freq / 2) / clk_freq;
    endfunction

endpackage

// File: rtl/hc_sr04_distance_filter_avg.sv
// Power-of-two moving average: ring buffer plus running sum. A prime
// request fills every slot with the incoming value so the average equals
// the sample immediately. avg_next is the average including the current
// input, valid combinationally in the update cycle.
module pow2_moving_avg #(
    parameter int W    = 16,
    parameter int LOG2 = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         prime,
    input  logic [W-1:0] din,
    output logic [W-1:0] avg_next
);

    localparam int N  = 1 << LOG2;
    localparam int SW = W + LOG2;

    logic [N-1:0][W-1:0] win_q;
    logic [LOG2-1:0]     ptr_q;   // slot holding the oldest sample
    logic [SW-1:0]       sum_q;
    logic [SW-1:0]       sum_nxt;

    // New sum: either a full prime or drop-oldest / add-newest.
    always_comb begin
        sum_nxt = sum_q;
        if (prime)
            sum_nxt = SW'(din) << LOG2;
        else
            sum_nxt = sum_q - SW'(win_q[ptr_q]) + SW'(din);
        avg_next = W'(sum_nxt >> LOG2);
    end

    // Ring buffer and running sum update on each accepted sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            ptr_q <= '0;
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_nxt;
            if (prime) begin
                win_q <= {N{din}};
                ptr_q <= '0;
            end else begin
                win_q[ptr_q] <= din;
                ptr_q        <= ptr_q + LOG2'(1);
            end
        end
    end

endmodule

// File: rtl/hc_sr04_distance_filter.sv
// Converts HC-SR04 echo tick counts to centimetres, smooths them with a
// power-of-two moving average, flags near obstacles with hysteresis and
// declares a sensor fault when samples stop arriving.
// Pipeline: S1 clamp+multiply, S2 round+saturate, S3 average/compare.
module hc_sr04_distance_filter
    import hc_sr04_pkg::*;
#(
    parameter int CLK_FREQ       = 100000000,
    parameter int MAX_DISTANCE_M = 4,
    parameter int TICK_WL        = 32,
    parameter int DIST_WL        = 16,
    parameter int AVG_LOG2       = 2,
    parameter int NEAR_CM        = 30,
    parameter int HYST_CM        = 5,
    parameter int TIMEOUT_MS     = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [TICK_WL-1:0] edge_ticks,
    output logic               o_valid,
    output logic [DIST_WL-1:0] dist_raw_cm,
    output logic [DIST_WL-1:0] dist_avg_cm,
    output logic               near_obstacle,
    output logic               sensor_fault
);

    localparam longint MAX_TICKS_L = calc_max_ticks(CLK_FREQ, MAX_DISTANCE_M);
    localparam longint K_L         = calc_k(CLK_FREQ);
    localparam longint TO_LIMIT_L  = (longint'(TIMEOUT_MS) * CLK_FREQ) / 1000;
    localparam int     TO_W        = $clog2(TO_LIMIT_L + 1);
    localparam int     PROD_WL     = TICK_WL + 32;

    localparam logic [TICK_WL-1:0] MAX_TICKS = TICK_WL'(MAX_TICKS_L);
    localparam logic [31:0]        K         = 32'(K_L);
    localparam logic [TO_W-1:0]    TO_LIMIT  = TO_W'(TO_LIMIT_L);
    localparam logic [DIST_WL-1:0] DIST_MAX  = '1;
    localparam logic [DIST_WL-1:0] NEAR_SET  = DIST_WL'(NEAR_CM);
    localparam logic [DIST_WL-1:0] NEAR_CLR  = DIST_WL'(NEAR_CM + HYST_CM);
    localparam logic [PROD_WL:0]   RND_HALF  = (PROD_WL + 1)'(1) << (CM_SCALE_LOG2 - 1);

    // vld_pipe[s] marks a sample leaving stage s; vld_pipe[3] is o_valid.
    logic [3:1]         vld_pipe;
    logic [TICK_WL-1:0] ticks_clamped;
    logic [PROD_WL-1:0] prod_s1;
    logic [PROD_WL:0]   rnd_full;
    logic [PROD_WL:0]   cm_full;
    logic [DIST_WL-1:0] cm_sat;
    logic [DIST_WL-1:0] cm_s2;
    logic [DIST_WL-1:0] avg_next;
    logic [TO_W-1:0]    to_cnt;
    logic               timeout_hit;
    logic               prime;
    logic               near_q;

    dist_filt_state_t   state, state_nxt;

    assign o_valid       = vld_pipe[3];
    assign near_obstacle = near_q;

    // Valid bits advance one stage per cycle; no stalls.
    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[2:1], i_valid};
    end

    // S1: saturate ticks at the range ceiling, then scale by K.
    always_comb begin
        ticks_clamped = (edge_ticks > MAX_TICKS) ? MAX_TICKS : edge_ticks;
    end

    // S1 register: Q24 centimetre product.
    always_ff @(posedge clk) begin
        if (reset)        prod_s1 <= '0;
        else if (i_valid) prod_s1 <= PROD_WL'(ticks_clamped) * PROD_WL'(K);
    end

    // S2: round Q24 to nearest cm and saturate to the output width.
    always_comb begin
        rnd_full = {1'b0, prod_s1} + RND_HALF;
        cm_full  = rnd_full >> CM_SCALE_LOG2;
        cm_sat   = (cm_full > (PROD_WL + 1)'(DIST_MAX)) ? DIST_MAX : cm_full[DIST_WL-1:0];
    end

    // S2 register.
    always_ff @(posedge clk) begin
        if (reset)            cm_s2 <= '0;
        else if (vld_pipe[1]) cm_s2 <= cm_sat;
    end

    // S3: window update; primed whenever the filter is not tracking.
    pow2_moving_avg #(
        .W    (DIST_WL),
        .LOG2 (AVG_LOG2)
    ) u_avg (
        .clk      (clk),
        .reset    (reset),
        .en       (vld_pipe[2]),
        .prime    (prime),
        .din      (cm_s2),
        .avg_next (avg_next)
    );

    // Cycles since the last i_valid; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset)                 to_cnt <= '0;
        else if (i_valid)          to_cnt <= '0;
        else if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + TO_W'(1);
    end

    // Expiry on this edge; a simultaneous i_valid cancels it.
    assign timeout_hit = !i_valid && (to_cnt == TO_LIMIT - TO_W'(1));

    // S3 outputs: distances and hysteretic near flag; fault clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_raw_cm <= '0;
            dist_avg_cm <= '0;
            near_q      <= 1'b0;
        end else if (vld_pipe[2]) begin
            dist_raw_cm <= cm_s2;
            dist_avg_cm <= avg_next;
            if (avg_next < NEAR_SET)      near_q <= 1'b1;
            else if (avg_next > NEAR_CLR) near_q <= 1'b0;
        end else if (timeout_hit) begin
            near_q <= 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // FSM next state: a sample reaching S3 always returns to tracking.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY, FAULT: begin
                if (vld_pipe[2])      state_nxt = TRACKING;
                else if (timeout_hit) state_nxt = FAULT;
            end
            TRACKING: begin
                if (timeout_hit) state_nxt = FAULT;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // FSM outputs.
    always_comb begin
        prime        = (state != TRACKING);
        sensor_fault = (state == FAULT);
    end

endmodule

// File: tb/tb_hc_sr04_distance_filter.sv
// Directed bench for hc_sr04_distance_filter. u0 runs at default
// parameters; u1 uses a 1 MHz clock rate and a 2 ms timeout so a fault
// can be provoked in about 2000 cycles. Both share the same stimulus.
module tb_hc_sr04_distance_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] edge_ticks;

    logic        ov0, near0, flt0;
    logic [15:0] raw0, avg0;
    logic        ov1, near1, flt1;
    logic [15:0] raw1, avg1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hc_sr04_distance_filter u0 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .edge_ticks(edge_ticks),
        .o_valid(ov0), .dist_raw_cm(raw0), .dist_avg_cm(avg0),
        .near_obstacle(near0), .sensor_fault(flt0)
    );

    hc_sr04_distance_filter #(.CLK_FREQ(1000000), .TIMEOUT_MS(2)) u1 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .edge_ticks(edge_ticks),
        .o_valid(ov1), .dist_raw_cm(raw1), .dist_avg_cm(avg1),
        .near_obstacle(near1), .sensor_fault(flt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One pulse, then wait (bounded) for u0's o_valid; lat counts cycles
    // from the i_valid cycle.
    task automatic send(input logic [31:0] t, output int lat);
        @(negedge clk); i_valid = 1'b1; edge_ticks = t;
        @(negedge clk); i_valid = 1'b0; edge_ticks = '0; lat = 1;
        while (!ov0 && lat < 8) begin
            @(negedge clk); lat++;
        end
    endtask

    // Sequence after priming at 100 cm (100 cm @ 100 MHz = 588235 ticks).
    logic [31:0] tk   [22] = '{1176471, 1176471, 1176471, 1176471, 32'hFFFF_FFFF, 0,
                               170588, 170588, 170588, 170588,
                               194118, 194118, 194118, 194118,
                               211765, 211765, 211765, 211765,
                               200000, 200000, 200000, 200000};
    int          e_raw[22] = '{200, 200, 200, 200, 400, 0, 29, 29, 29, 29,
                               33, 33, 33, 33, 36, 36, 36, 36, 34, 34, 34, 34};
    int          e_avg[22] = '{125, 150, 175, 200, 250, 200, 157, 114, 21, 29,
                               30, 31, 32, 33, 33, 34, 35, 36, 35, 35, 34, 34};
    int          e_near[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                                1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    initial begin
        int lat;
        int seen;
        int e_tp[4] = '{50, 67, 83, 100};

        reset = 1'b1; i_valid = 1'b0; edge_ticks = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ovalid", ov0, 0);
        chk("rst_raw", raw0, 0);
        chk("rst_avg", avg0, 0);
        chk("rst_near", near0, 0);
        chk("rst_fault", flt0, 0);

        // Conversion and priming from EMPTY.
        send(588235, lat);
        chk("conv_lat", lat, 3);
        chk("conv_raw", raw0, 100);
        chk("conv_avg", avg0, 100);
        chk("conv_near", near0, 0);
        @(negedge clk);
        chk("conv_pulse_1cyc", ov0, 0);

        // Averaging, clamp/zero and hysteresis.
        for (int i = 0; i < 22; i++) begin
            send(tk[i], lat);
            chk($sformatf("seq%0d_lat", i), lat, 3);
            chk($sformatf("seq%0d_raw", i), raw0, e_raw[i]);
            chk($sformatf("seq%0d_avg", i), avg0, e_avg[i]);
            chk($sformatf("seq%0d_near", i), near0, e_near[i]);
        end

        // Throughput: four back-to-back 100 cm samples over a window of 34s.
        @(negedge clk); i_valid = 1'b1; edge_ticks = 588235;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                // fourth sample is still being driven this cycle
            end else begin
                i_valid = 1'b0;
            end
            chk($sformatf("tp%0d_ovalid", i), ov0, 1);
            chk($sformatf("tp%0d_raw", i), raw0, 100);
            chk($sformatf("tp%0d_avg", i), avg0, e_tp[i]);
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("tp_end_ovalid", ov0, 0);
        chk("tp_hold_avg", avg0, 100);

        // Reset one cycle after i_valid kills the in-flight sample.
        @(negedge clk); i_valid = 1'b1; edge_ticks = 588235;
        @(negedge clk); i_valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ov0 === 1'b1) seen = 1;
            @(negedge clk);
        end
        chk("midrst_no_ovalid", seen, 0);
        chk("midrst_raw", raw0, 0);
        chk("midrst_avg", avg0, 0);
        chk("midrst_near", near0, 0);

        // Timeout on u1 (limit 2000 cycles); 1706 ticks = 29 cm at 1 MHz.
        send(1706, lat);
        chk("to_prime_ovalid", ov1, 1);
        chk("to_prime_avg", avg1, 29);
        chk("to_prime_near", near1, 1);
        repeat (1900) @(negedge clk);
        chk("to_before_fault", flt1, 0);
        repeat (200) @(negedge clk);
        chk("to_fault", flt1, 1);
        chk("to_fault_near", near1, 0);
        chk("to_fault_avg_hold", avg1, 29);
        chk("to_u0_no_fault", flt0, 0);

        // Recovery: 5882 ticks = 100 cm at 1 MHz, re-primes the window.
        send(5882, lat);
        chk("rec_ovalid", ov1, 1);
        chk("rec_fault_clear", flt1, 0);
        chk("rec_raw", raw1, 100);
        chk("rec_avg", avg1, 100);
        chk("rec_near", near1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
